// File: rtl/pio_edge_irq_gen2_if.sv
// Avalon-MM slave bus bundle for the edge-capture PIO interrupt block.
// The level interrupt travels with the bus so one interface connects the slave to the Nios.
interface pio_edge_irq_gen2_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/pio_edge_irq_gen2.sv
// Edge-capture PIO interrupt slave: synchronizes and debounces inputs, captures
// selected rising/falling edges into a W1C register and raises a masked level irq.
module pio_edge_irq_gen2 #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_W        = 8,
    parameter int unsigned DB_RESET    = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     in_port,
    pio_edge_irq_gen2_if.slave   bus
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_CAPTURE  = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
    localparam logic [2:0] ADDR_DEBOUNCE = 3'd5;
    localparam logic [2:0] ADDR_PENDING  = 3'd6;

    function automatic logic [31:0] zext_bits(input logic [WIDTH-1:0] v);
        return 32'(v);
    endfunction

    function automatic logic [31:0] zext_db(input logic [DB_W-1:0] v);
        return 32'(v);
    endfunction

    logic             wr_en;
    logic [WIDTH-1:0] wr_bits;
    logic             unused_wdata;

    logic [WIDTH-1:0] sync_p [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;
    logic [DB_W-1:0]  cnt [WIDTH];
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev;

    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] capture;
    logic [DB_W-1:0]  debounce;

    logic [WIDTH-1:0] rise_evt;
    logic [WIDTH-1:0] fall_evt;
    logic [WIDTH-1:0] clr_bits;

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign wr_bits      = bus.writedata[WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;

    // Input synchronizer chain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) sync_p[s] <= '0;
        end else begin
            sync_p[0] <= in_port;
            for (int s = 1; s < int'(SYNC_STAGES); s++) sync_p[s] <= sync_p[s-1];
        end
    end

    assign sync_out = sync_p[SYNC_STAGES-1];

    // Debounce: stable adopts sync_out once it has disagreed for D+1 consecutive clocks.
    // The >= compare lets a shrinking DEBOUNCE release a counter already past it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= '0;
            for (int b = 0; b < int'(WIDTH); b++) cnt[b] <= '0;
        end else begin
            for (int b = 0; b < int'(WIDTH); b++) begin
                if (sync_out[b] == stable[b]) begin
                    cnt[b] <= '0;
                end else if (cnt[b] >= debounce) begin
                    stable[b] <= sync_out[b];
                    cnt[b]    <= '0;
                end else begin
                    cnt[b] <= cnt[b] + 1'b1;
                end
            end
        end
    end

    // Edge detection on the debounced value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev <= '0;
        else          prev <= stable;
    end

    assign rise_evt = stable & ~prev & rise_en;
    assign fall_evt = ~stable & prev & fall_en;
    assign clr_bits = (wr_en && bus.address == ADDR_CAPTURE) ? wr_bits : '0;

    // Register file; a same-cycle event beats a W1C clear so no edge is lost
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en  <= '0;
            fall_en  <= '0;
            irq_mask <= '0;
            capture  <= '0;
            debounce <= DB_W'(DB_RESET);
        end else begin
            capture <= (capture & ~clr_bits) | rise_evt | fall_evt;
            if (wr_en) begin
                case (bus.address)
                    ADDR_RISE_EN:  rise_en  <= wr_bits;
                    ADDR_IRQ_MASK: irq_mask <= wr_bits;
                    ADDR_FALL_EN:  fall_en  <= wr_bits;
                    ADDR_DEBOUNCE: debounce <= bus.writedata[DB_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Registered read mux, one cycle latency regardless of chipselect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            case (bus.address)
                ADDR_DATA:     bus.readdata <= zext_bits(stable);
                ADDR_RISE_EN:  bus.readdata <= zext_bits(rise_en);
                ADDR_IRQ_MASK: bus.readdata <= zext_bits(irq_mask);
                ADDR_CAPTURE:  bus.readdata <= zext_bits(capture);
                ADDR_FALL_EN:  bus.readdata <= zext_bits(fall_en);
                ADDR_DEBOUNCE: bus.readdata <= zext_db(debounce);
                ADDR_PENDING:  bus.readdata <= zext_bits(capture & irq_mask);
                default:       bus.readdata <= '0;
            endcase
        end
    end

    assign bus.irq = |(capture & irq_mask);

endmodule

// File: tb/tb_pio_edge_irq_gen2.sv
// Randomized and directed bench for pio_edge_irq_gen2 against a behavioural model.
module tb_pio_edge_irq_gen2;

    localparam int W   = 8;
    localparam int SS  = 2;
    localparam int DBW = 8;
    localparam int DBR = 0;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] in_port;

    pio_edge_irq_gen2_if bus ();

    pio_edge_irq_gen2 #(
        .WIDTH(W), .SYNC_STAGES(SS), .DB_W(DBW), .DB_RESET(DBR)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_port(in_port),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: delay line for the synchronizer, run-lengths of disagreement
    // for the debounce, and plain register variables for the map.
    logic [W-1:0] m_sync[$];
    logic [W-1:0] m_stable, m_prev, m_rise, m_fall, m_mask, m_cap;
    int           m_run[W];
    int           m_db;
    logic [31:0]  m_rd;

    task automatic m_reset();
        m_sync = {};
        repeat (SS) m_sync.push_back('0);
        m_stable = '0; m_prev = '0; m_rise = '0; m_fall = '0; m_mask = '0; m_cap = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
        m_db = DBR;
        m_rd = '0;
    endtask

    task automatic m_step(input logic [W-1:0] pin, input bit we, input logic [2:0] a,
                          input logic [31:0] wd);
        logic [W-1:0] lvl, ev, nstable, clr;
        logic [31:0]  rd;
        lvl = m_sync[SS-1];
        case (a)
            3'd0: rd = 32'(m_stable);
            3'd1: rd = 32'(m_rise);
            3'd2: rd = 32'(m_mask);
            3'd3: rd = 32'(m_cap);
            3'd4: rd = 32'(m_fall);
            3'd5: rd = 32'(m_db);
            3'd6: rd = 32'(m_cap & m_mask);
            default: rd = 32'd0;
        endcase
        ev = (m_stable & ~m_prev & m_rise) | (~m_stable & m_prev & m_fall);
        nstable = m_stable;
        for (int i = 0; i < W; i++) begin
            if (lvl[i] != m_stable[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] > m_db) begin
                    nstable[i] = lvl[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_prev   = m_stable;
        m_stable = nstable;
        clr      = (we && a == 3'd3) ? wd[W-1:0] : '0;
        m_cap    = (m_cap & ~clr) | ev;
        if (we) begin
            case (a)
                3'd1: m_rise = wd[W-1:0];
                3'd2: m_mask = wd[W-1:0];
                3'd4: m_fall = wd[W-1:0];
                3'd5: m_db   = int'(wd) & ((1 << DBW) - 1);
                default: ;
            endcase
        end
        m_sync.push_front(pin);
        void'(m_sync.pop_back());
        m_rd = rd;
    endtask

    task automatic tick();
        logic [W-1:0] pin;
        bit           we;
        logic [2:0]   a;
        logic [31:0]  wd;
        pin = in_port;
        we  = bus.chipselect && !bus.write_n;
        a   = bus.address;
        wd  = bus.writedata;
        @(posedge clk);
        m_step(pin, we, a, wd);
        @(negedge clk);
        check("readdata", bus.readdata, m_rd);
        check("irq", 32'(bus.irq), 32'(|(m_cap & m_mask)));
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
        tick();
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bus.address = a;
        tick();
        d = bus.readdata;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        bus.address = 3'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        in_port = '0;
        m_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check("rst_rd", bus.readdata, 32'd0);
        check("rst_irq", 32'(bus.irq), 32'd0);

        // Reset values of every address
        for (int a = 0; a < 8; a++) rd(3'(a), v);
        rd(3'd5, v); check("rst_db", v, DBR);
        rd(3'd3, v); check("rst_cap", v, 32'd0);

        // Rising capture with D=0, latency to irq
        wr(3'd1, 32'hFF);
        wr(3'd2, 32'h01);
        bus.address = 3'd3;
        in_port = 8'h01;
        hold(3);
        check("lat3_irq", 32'(bus.irq), 32'd0);
        tick();
        check("lat4_irq", 32'(bus.irq), 32'd1);
        wr(3'd3, 32'h01);
        check("w1c_irq", 32'(bus.irq), 32'd0);
        rd(3'd3, v); check("w1c_cap", v, 32'd0);

        // Falling / both edges
        in_port = 8'h00;
        hold(6);
        wr(3'd3, 32'hFF);
        wr(3'd1, 32'h02);
        wr(3'd4, 32'h06);
        in_port = 8'h06;
        hold(5);
        rd(3'd3, v); check("rise_only", v, 32'h02);
        hold(4);
        in_port = 8'h00;
        hold(8);
        rd(3'd3, v); check("both_edges", v, 32'h06);

        // Debounce D=5: short glitch rejected, long pulse accepted
        wr(3'd3, 32'hFF);
        wr(3'd5, 32'd5);
        wr(3'd1, 32'h01);
        wr(3'd4, 32'h00);
        in_port = 8'h01;
        hold(3);
        in_port = 8'h00;
        hold(12);
        rd(3'd0, v); check("glitch_data", v, 32'd0);
        rd(3'd3, v); check("glitch_cap", v, 32'd0);
        bus.address = 3'd3;
        in_port = 8'h01;
        hold(6);
        in_port = 8'h00;
        hold(2);
        check("db_lat8_irq", 32'(bus.irq), 32'd0);
        tick();
        check("db_lat9_irq", 32'(bus.irq), 32'd1);
        rd(3'd0, v); check("db_data", v, 32'h01);
        rd(3'd3, v); check("db_cap", v, 32'h01);
        hold(15);

        // Set-priority W1C on bit3, bit1 kept
        wr(3'd3, 32'hFF);
        wr(3'd5, 32'd0);
        wr(3'd1, 32'hFF);
        in_port = 8'h02;
        hold(6);
        in_port = 8'h0A;
        hold(3);
        wr(3'd3, 32'h08);
        rd(3'd3, v); check("setprio", v, 32'h0A);
        wr(3'd3, 32'h08);
        rd(3'd3, v); check("w1c_keep", v, 32'h02);

        // Asynchronous reset with debounce counts in flight
        wr(3'd2, 32'hFF);
        wr(3'd5, 32'd20);
        in_port = 8'hF5;
        hold(8);
        check("pre_rst_irq", 32'(bus.irq), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rd", bus.readdata, 32'd0);
        check("async_irq", 32'(bus.irq), 32'd0);
        m_reset();
        in_port = 8'h00;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        hold(30);
        rd(3'd5, v); check("rst_db2", v, DBR);
        rd(3'd2, v); check("rst_mask2", v, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 9) == 0) in_port = W'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                logic [2:0]  a;
                logic [31:0] d;
                a = 3'($urandom_range(0, 7));
                d = $urandom;
                if (a == 3'd5) d = 32'($urandom_range(0, 6));
                wr(a, d);
            end else begin
                bus.address = 3'($urandom_range(0, 7));
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
